// File: rtl/correlator_multi.sv
// Windowed correlator: counts X, Y[k], X&Y[k] and X^Y[k] over 2**L strobes,
// normalises each count to a byte and streams a (2+3*N_CH)-byte packet.
module correlator_multi #(
  parameter int unsigned N_CH                  = 2,
  parameter int unsigned MAX_WINDOW_LENGTH_EXP = 16,
  parameter int unsigned WINDOW_LENGTH_EXP_W   = $clog2(MAX_WINDOW_LENGTH_EXP + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cg,
  input  logic                           i_strobe,
  input  logic                           i_x,
  input  logic [N_CH-1:0]                i_y,
  input  logic [WINDOW_LENGTH_EXP_W-1:0] i_windowLengthExp,
  input  logic                           i_flush,
  output logic [7:0]                     o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [7:0]                     o_winNum,
  output logic [7:0]                     o_dropCount
);

  localparam int unsigned TW = MAX_WINDOW_LENGTH_EXP;
  localparam int unsigned CW = MAX_WINDOW_LENGTH_EXP + 1;
  localparam int unsigned NB = 2 + 3 * N_CH;
  localparam int unsigned IW = $clog2(NB);
  localparam logic [WINDOW_LENGTH_EXP_W-1:0] LMax = WINDOW_LENGTH_EXP_W'(MAX_WINDOW_LENGTH_EXP);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic                           valid_q, valid_d;
  logic [7:0]                     data_q, data_d;
  logic [7:0]                     win_q, win_d;
  logic [7:0]                     drop_q, drop_d;
  logic [TW-1:0]                  t_q, t_d;
  logic [WINDOW_LENGTH_EXP_W-1:0] lq_q, lq_d;
  logic [CW-1:0]                  cx_q, cx_d;
  logic [CW-1:0]                  cy_q [N_CH];
  logic [CW-1:0]                  cy_d [N_CH];
  logic [CW-1:0]                  ci_q [N_CH];
  logic [CW-1:0]                  ci_d [N_CH];
  logic [CW-1:0]                  cs_q [N_CH];
  logic [CW-1:0]                  cs_d [N_CH];
  logic [7:0]                     pkt_q [NB];
  logic [7:0]                     pkt_d [NB];

  logic [CW-1:0]                  cx_sum;
  logic [CW-1:0]                  cy_sum [N_CH];
  logic [CW-1:0]                  ci_sum [N_CH];
  logic [CW-1:0]                  cs_sum [N_CH];
  logic [WINDOW_LENGTH_EXP_W-1:0] l_eff;
  logic [TW-1:0]                  mask;
  logic                           strobe, hs, last, l_chg, wrap;

  // Count scaled by 2**(8-L), saturated to one byte.
  function automatic logic [7:0] norm_byte(input logic [CW-1:0]                  c,
                                           input logic [WINDOW_LENGTH_EXP_W-1:0] l);
    logic [CW+7:0] w;
    if (int'(l) >= 8) w = {8'd0, c} >> (int'(l) - 8);
    else              w = {8'd0, c} << (8 - int'(l));
    return (|w[CW+7:8]) ? 8'hFF : w[7:0];
  endfunction

  assign strobe = i_cg & i_strobe;
  assign hs     = i_cg & valid_q & i_ready;
  assign last   = hs & (idx_q == IW'(NB - 1));
  assign l_chg  = i_windowLengthExp != lq_q;
  assign l_eff  = (lq_q > LMax) ? LMax : lq_q;
  assign wrap   = strobe & ((t_q & mask) == mask);

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(TW); i++) mask[i] = (i < int'(l_eff));
  end

  // Counts including the sample presented this cycle.
  always_comb begin
    cx_sum = cx_q + CW'(i_x);
    for (int k = 0; k < int'(N_CH); k++) begin
      cy_sum[k] = cy_q[k] + CW'(i_y[k]);
      ci_sum[k] = ci_q[k] + CW'(i_x & i_y[k]);
      cs_sum[k] = cs_q[k] + CW'(i_x ^ i_y[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    win_d   = win_q;
    drop_d  = drop_q;
    t_d     = t_q;
    lq_d    = lq_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ci_d    = ci_q;
    cs_d    = cs_q;
    pkt_d   = pkt_q;

    if (i_cg) begin
      lq_d = i_windowLengthExp;
      if (i_flush) begin
        state_d = StIdle;
        valid_d = 1'b0;
        t_d     = '0;
        cx_d    = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
          cy_d[k] = '0;
          ci_d[k] = '0;
          cs_d[k] = '0;
        end
      end else begin
        if (hs) begin
          if (last) begin
            state_d = StIdle;
            valid_d = 1'b0;
          end else begin
            idx_d  = idx_q + IW'(1);
            data_d = pkt_q[idx_q + IW'(1)];
          end
        end

        // A length change restarts the window and swallows this cycle's strobe.
        if (l_chg || wrap) begin
          t_d  = '0;
          cx_d = '0;
          for (int k = 0; k < int'(N_CH); k++) begin
            cy_d[k] = '0;
            ci_d[k] = '0;
            cs_d[k] = '0;
          end
        end else if (strobe) begin
          t_d  = t_q + TW'(1);
          cx_d = cx_sum;
          cy_d = cy_sum;
          ci_d = ci_sum;
          cs_d = cs_sum;
        end

        if (!l_chg && wrap) begin
          win_d = win_q + 8'd1;
          if (state_q == StIdle || last) begin
            pkt_d[0] = win_q;
            pkt_d[1] = norm_byte(cx_sum, l_eff);
            for (int k = 0; k < int'(N_CH); k++) begin
              pkt_d[2 + 3 * k] = norm_byte(cy_sum[k], l_eff);
              pkt_d[3 + 3 * k] = norm_byte(ci_sum[k], l_eff);
              pkt_d[4 + 3 * k] = norm_byte(cs_sum[k], l_eff);
            end
            state_d = StSend;
            valid_d = 1'b1;
            idx_d   = '0;
            data_d  = win_q;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      win_q   <= '0;
      drop_q  <= '0;
      t_q     <= '0;
      lq_q    <= '0;
      cx_q    <= '0;
      for (int k = 0; k < int'(N_CH); k++) begin
        cy_q[k] <= '0;
        ci_q[k] <= '0;
        cs_q[k] <= '0;
      end
      for (int i = 0; i < int'(NB); i++) pkt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      win_q   <= win_d;
      drop_q  <= drop_d;
      t_q     <= t_d;
      lq_q    <= lq_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ci_q    <= ci_d;
      cs_q    <= cs_d;
      pkt_q   <= pkt_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_winNum    = win_q;
  assign o_dropCount = drop_q;

endmodule

// File: tb/tb_correlator_multi.sv
// Bench for correlator_multi: directed packet checks plus randomized traffic
// compared every cycle against an integer-level window/packet model.
module tb_correlator_multi;
  localparam int NCH  = 2;
  localparam int MAXL = 16;
  localparam int LW   = 5;
  localparam int NB   = 2 + 3 * NCH;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cg = 1'b1, strobe = 1'b0, x = 1'b0, flush = 1'b0, ready = 1'b0;
  logic [NCH-1:0] y = '0;
  logic [LW-1:0]  wl = '0;
  logic [7:0]     o_data, o_winNum, o_dropCount;
  logic           o_valid;

  int checks = 0;
  int failures = 0;

  logic [7:0] got [$];
  logic [7:0] exp_b [NB];

  // Model state
  int     m_busy, m_idx, m_win, m_drop, m_lq;
  longint m_t;
  int     m_cx;
  int     m_cy [NCH];
  int     m_ci [NCH];
  int     m_cs [NCH];
  int     m_pkt [NB];

  correlator_multi #(
    .N_CH                 (NCH),
    .MAX_WINDOW_LENGTH_EXP(MAXL),
    .WINDOW_LENGTH_EXP_W  (LW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cg             (cg),
    .i_strobe         (strobe),
    .i_x              (x),
    .i_y              (y),
    .i_windowLengthExp(wl),
    .i_flush          (flush),
    .o_data           (o_data),
    .o_valid          (o_valid),
    .i_ready          (ready),
    .o_winNum         (o_winNum),
    .o_dropCount      (o_dropCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mnorm(input int c, input int l);
    longint v;
    v = (longint'(c) * 256) / (longint'(1) << l);
    return (v > 255) ? 255 : int'(v);
  endfunction

  function automatic void m_clear();
    m_t  = 0;
    m_cx = 0;
    for (int k = 0; k < NCH; k++) begin
      m_cy[k] = 0; m_ci[k] = 0; m_cs[k] = 0;
    end
  endfunction

  function automatic void m_reset();
    m_busy = 0; m_idx = 0; m_win = 0; m_drop = 0; m_lq = 0;
    for (int i = 0; i < NB; i++) m_pkt[i] = 0;
    m_clear();
  endfunction

  function automatic void m_step();
    int     acc, lst, le;
    longint per;
    if (!cg) return;
    acc = m_busy && ready;
    lst = acc && (m_idx == NB - 1);
    if (flush) begin
      m_busy = 0;
      m_lq   = int'(wl);
      m_clear();
      return;
    end
    if (acc) begin
      if (lst) m_busy = 0;
      else     m_idx++;
    end
    if (int'(wl) != m_lq) begin
      m_lq = int'(wl);
      m_clear();
    end else if (strobe) begin
      m_cx += int'(x);
      for (int k = 0; k < NCH; k++) begin
        m_cy[k] += int'(y[k]);
        m_ci[k] += int'(x & y[k]);
        m_cs[k] += int'(x ^ y[k]);
      end
      le  = (m_lq > MAXL) ? MAXL : m_lq;
      per = longint'(1) << le;
      if (m_t % per == per - 1) begin
        if (!m_busy) begin
          m_pkt[0] = m_win;
          m_pkt[1] = mnorm(m_cx, le);
          for (int k = 0; k < NCH; k++) begin
            m_pkt[2 + 3 * k] = mnorm(m_cy[k], le);
            m_pkt[3 + 3 * k] = mnorm(m_ci[k], le);
            m_pkt[4 + 3 * k] = mnorm(m_cs[k], le);
          end
          m_busy = 1;
          m_idx  = 0;
        end else if (m_drop < 255) begin
          m_drop++;
        end
        m_win = (m_win + 1) % 256;
        m_clear();
      end else begin
        m_t = (m_t + 1) % (longint'(1) << MAXL);
      end
    end
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  // Per-cycle compare against the model, plus byte collection for literal checks.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("valid", o_valid, m_busy);
        if (m_busy != 0) chk("data", o_data, m_pkt[m_idx]);
        chk("winnum", o_winNum, m_win);
        chk("dropcount", o_dropCount, m_drop);
        if (o_valid && ready && cg) got.push_back(o_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got.delete();
  endtask

  task automatic check_pkt(input string nm, input int base);
    for (int i = 0; i < NB; i++) begin
      if (base + i < got.size()) chk(nm, got[base + i], exp_b[i]);
      else                        chk(nm, 32'hFFFF_FFFF, exp_b[i]);
    end
  endtask

  task automatic strobes(input int n);
    strobe = 1'b1;
    repeat (n) step();
    strobe = 1'b0;
  endtask

  initial begin
    // Reset values
    cg = 1; ready = 1; x = 1; y = 2'b01; wl = 5'd4; flush = 0; strobe = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_winnum", o_winNum, 0);
    chk("rst_drop", o_dropCount, 0);
    rst = 1'b0;

    // L=4, full-window X and Y0
    step();
    strobe = 1;
    for (int s = 1; s <= 16; s++) begin
      step();
      if (s == 15) chk("t1_valid_early", o_valid, 0);
      if (s == 16) chk("t1_valid_rise", o_valid, 1);
    end
    strobe = 0;
    repeat (9) step();
    chk("t1_len", got.size(), NB);
    exp_b = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
    check_pkt("t1_byte", 0);

    // L=10, half-density X
    wl = 5'd10; y = 2'b11;
    do_reset();
    step();
    strobe = 1;
    for (int s = 0; s < 1024; s++) begin
      x = (s % 2 == 0);
      step();
    end
    strobe = 0;
    repeat (9) step();
    chk("t2_len", got.size(), NB);
    exp_b = '{8'h00, 8'h80, 8'hFF, 8'h80, 8'h80, 8'hFF, 8'h80, 8'h80};
    check_pkt("t2_byte", 0);

    // L=2 with consumer stalled: drops and held data
    wl = 5'd2; x = 1; y = 2'b11; ready = 0;
    do_reset();
    step();
    strobes(4);
    chk("t3_data_first", o_data, 0);
    strobes(8);
    step();
    chk("t3_drop", o_dropCount, 2);
    chk("t3_winnum", o_winNum, 3);
    chk("t3_valid_held", o_valid, 1);
    chk("t3_data_held", o_data, 0);
    ready = 1;
    repeat (9) step();
    strobes(4);
    repeat (9) step();
    chk("t3_len", got.size(), 2 * NB);
    exp_b = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
    check_pkt("t3_byte", 0);
    if (got.size() > NB) chk("t3_hdr2", got[NB], 8'h03);
    else                  chk("t3_hdr2", 32'hFFFF_FFFF, 8'h03);

    // L=0, back-to-back packets on the last-byte handshake
    wl = 5'd0; x = 1; y = 2'b00; ready = 1;
    do_reset();
    step();
    for (int p = 0; p < 3; p++) begin
      strobes(1);
      repeat (7) step();
    end
    repeat (9) step();
    chk("t4_len", got.size(), 3 * NB);
    for (int p = 0; p < 3; p++) begin
      exp_b = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
      exp_b[0] = 8'(p);
      check_pkt("t4_byte", p * NB);
    end
    chk("t4_drop", o_dropCount, 0);

    // L change mid-window
    wl = 5'd4; x = 1; y = 2'b10;
    do_reset();
    step();
    strobes(7);
    wl = 5'd5;
    strobes(1);
    chk("t5_nopkt", o_valid, 0);
    strobes(31);
    chk("t5_valid_early", o_valid, 0);
    strobes(1);
    chk("t5_valid_rise", o_valid, 1);
    repeat (9) step();
    chk("t5_len", got.size(), NB);
    exp_b = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    check_pkt("t5_byte", 0);

    // Asynchronous reset mid-packet
    wl = 5'd1; x = 1; y = 2'b01; ready = 0;
    do_reset();
    step();
    strobes(4);
    step();
    chk("t6_valid_pre", o_valid, 1);
    chk("t6_drop_pre", o_dropCount, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_valid", o_valid, 0);
    chk("t6_async_winnum", o_winNum, 0);
    chk("t6_async_drop", o_dropCount, 0);
    #2 rst = 1'b0;
    got.delete();

    // Flush on the wrap strobe
    step();
    strobes(1);
    flush = 1;
    strobes(1);
    flush = 0;
    chk("t7_valid", o_valid, 0);
    chk("t7_drop", o_dropCount, 0);
    chk("t7_winnum", o_winNum, 0);
    strobes(1);
    chk("t7_restart", o_valid, 0);
    strobes(1);
    chk("t7_pkt", o_valid, 1);
    chk("t7_winnum2", o_winNum, 1);
    ready = 1;
    repeat (9) step();

    // Randomized traffic against the model
    wl = 5'd2;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      cg     = ($urandom % 10) != 0;
      strobe = ($urandom % 3) != 0;
      x      = 1'($urandom);
      y      = NCH'($urandom);
      ready  = ($urandom % 4) != 0;
      flush  = ($urandom % 64) == 0;
      if ($urandom % 200 == 0) begin
        case ($urandom % 6)
          0: wl = 5'd0;
          1: wl = 5'd1;
          2: wl = 5'd2;
          3: wl = 5'd3;
          4: wl = 5'd5;
          default: wl = 5'd20;
        endcase
      end
      step();
    end
    cg = 1; flush = 0; strobe = 0; ready = 1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/correlator_multi.md
Name: correlator_multi

Overview:
- Next-generation windowed correlator: one reference input X against N_CH test inputs Y[k].
- Per window it accumulates rectangular counts of X, each Y[k], X&Y[k] (isect) and X^Y[k] (symdiff).
- At window end it normalises each count to 8 bits and emits a variable-length packet on a valid/ready byte stream.
- Sits between the sampling strobe generator and the packet FIFO feeding the register/BytePipe interface.

Parameters:
N_CH, 2, number of Y channels (1..8)
MAX_WINDOW_LENGTH_EXP, 16, window length is 2**L samples, L in 0..MAX_WINDOW_LENGTH_EXP
WINDOW_LENGTH_EXP_W, $clog2(MAX_WINDOW_LENGTH_EXP+1), width of L

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous active-high reset
i_cg  input  1  clock gate enable; when 0, all state holds
i_strobe  input  1  sample strobe; X/Y are sampled on cycles with i_cg && i_strobe
i_x  input  1  reference input
i_y  input  N_CH  test inputs
i_windowLengthExp  input  WINDOW_LENGTH_EXP_W  L; values above MAX are treated as MAX
i_flush  input  1  abort current packet and restart window
o_data  output  8  packet byte
o_valid  output  1  byte valid
i_ready  input  1  consumer accepts byte when o_valid && i_ready
o_winNum  output  8  current window number (wraps)
o_dropCount  output  8  saturating count of dropped packets

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: o_valid=0, o_data=0, o_winNum=0, o_dropCount=0. Also cleared: t, all counters, FSM=IDLE, Lq=0.
- Time counter t: width MAX_WINDOW_LENGTH_EXP. Increments on each strobe.
  - Wrap strobe: a strobe with t[L-1:0] all ones. For L=0, every strobe is a wrap strobe.
  - On a wrap strobe, t goes to 0 and o_winNum increments, including when the packet is dropped.
- Counters: width MAX_WINDOW_LENGTH_EXP+1, so a full window of 2**L cannot overflow.
  - On each strobe: cX += x; cY[k] += y[k]; cI[k] += x&y[k]; cS[k] += x^y[k].
  - Snapshot on a wrap strobe = counter plus the current sample's contribution. Counters then clear to 0.
- Normalisation to byte b from count c:
  - L>=8: b = c>>(L-8), saturated to 255.
  - L<8: b = c<<(8-L), saturated to 255.
  - Result: a full window gives 0xFF, and c = 2**(L-1) gives 0x80.
- Packet: 2+3*N_CH bytes, in this order:
  - winNum of the completed window (value before increment);
  - bX;
  - for k=0..N_CH-1: bY[k], bI[k], bS[k].
- FSM:
  - IDLE: o_valid=0. A wrap strobe captures normalised bytes into the snapshot register, sets idx=0, and moves to SEND.
  - SEND: o_valid=1 and o_data=byte[idx]. Data is stable while !i_ready. idx advances on each handshake.
  - A handshake on the last byte returns the FSM to IDLE.
- Latency: o_valid rises the cycle after the wrap strobe.
- Wrap strobe while in SEND, not on the last-byte handshake cycle: the new packet is dropped and o_dropCount increments (saturating at 255). The packet in flight continues unchanged.
- Wrap strobe on the same cycle as the last-byte handshake: the new packet is captured, the FSM stays in SEND with idx=0, and o_valid stays 1 with no bubble.
- L change: Lq registers i_windowLengthExp.
  - If i_windowLengthExp != Lq, then t and the counters clear, Lq updates, and no packet is produced.
  - A packet already in SEND completes normally.
  - A strobe on the change cycle is discarded.
- i_flush: FSM goes to IDLE, o_valid=0 next cycle, t and counters clear. o_winNum and o_dropCount are preserved.
- i_flush has priority over a simultaneous wrap strobe: no packet is produced and no drop is counted.
- i_cg=0: everything holds, including o_valid and o_data.
- Async reset mid-packet: o_valid drops to 0 immediately, without waiting for a clock edge.

Test Plan:
- Reset, then N_CH=2, L=4, i_ready=1, i_strobe=1 each cycle, x=1, y=2'b01 for 16 strobes -> 8 bytes: 00,FF,FF,FF,00,00,00,FF; o_valid first high the cycle after the 16th strobe.
- L=10, x toggles each strobe starting at 1, y=2'b11 constant -> bX=0x80, bY=FF,FF, bI=0x80, bS=0x80; header=00.
- L=2, i_ready=0 for 3 windows -> o_dropCount=2; first packet's bytes held stable; o_winNum=3. After releasing i_ready, the packet with header 00 is followed by the header 03 of the next window.
- L=0, x=1, y=0 each strobe, i_ready=1 with strobe every 8 cycles -> each packet: bX=FF (1<<8 saturated), bY=00, bS=FF; headers increment 00,01,02.
- Change L from 4 to 5 after 7 strobes -> no packet; the next packet appears after 32 further strobes with correct counts.
- Assert i_rst asynchronously mid-packet -> o_valid=0 without a clock edge; o_winNum=0 and o_dropCount=0. Also, i_flush on the same cycle as a wrap strobe -> no packet and no drop.
